// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for serial_add_ctrl; the master side issues requests and
// reads results.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             CO;

    modport master (
        output start, SUB, A, B,
        input  busy, done, S, CO
    );

    modport slave (
        input  start, SUB, A, B,
        output busy, done, S, CO
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. A single full-add cell with a registered carry
// processes one operand bit per cycle, LSB first.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_co;

    logic               w_half;
    logic               w_s_bit;
    logic               w_carry_d;

    // Two half-adder stages; their carries are ORed into the next carry.
    assign w_half    = r_a_sh[0] ^ r_b_sh[0];
    assign w_s_bit   = w_half ^ r_carry;
    assign w_carry_d = (r_a_sh[0] & r_b_sh[0]) | (r_carry & w_half);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_d = StRun;
                    w_accept  = 1'b1;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (bus.start) begin
                    w_state_d = StRun;
                    w_accept  = 1'b1;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with SUB.
            r_a_sh  <= bus.A;
            r_b_sh  <= bus.SUB ? ~bus.B : bus.B;
            r_carry <= bus.SUB;
            r_cnt   <= '0;
        end else if (r_state == StRun) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_carry_d;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_s     <= (r_s >> 1) | (WIDTH'(w_s_bit) << (WIDTH - 1));
            if (w_last) begin
                r_co <= w_carry_d;
            end
        end
    end

    assign bus.busy = (r_state == StRun);
    assign bus.done = (r_state == StDone);
    assign bus.S    = r_s;
    assign bus.CO   = r_co;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: an 8-bit instance for the main sequences
// and a 1-bit instance for the minimum-width case.
module tb_serial_add_ctrl;
    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   busy_len;
    exp_t sb[$];

    serial_add_ctrl_if #(.WIDTH(W)) bus ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Call between clock edges; the next rising edge accepts the request.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0] sum;
        exp_t       e;
        sum = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (W + 1)'(sub);
        e.s   = sum[W-1:0];
        e.co  = sum[W];
        e.cyc = cyc + 1 + W;
        sb.push_back(e);
        bus.A     = a;
        bus.B     = b;
        bus.SUB   = sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.SUB   = 1'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < bound);
        if (!bus.done) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_len = 0;
        end else begin
            if (bus.busy) busy_len++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("S", 32'(bus.S), 32'(e.s));
                    check_eq("CO", 32'(bus.CO), 32'(e.co));
                    check_eq("done_cycle", 32'(cyc), 32'(e.cyc));
                    check_eq("busy_len", 32'(busy_len), W);
                end
                busy_len = 0;
            end
        end
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        busy_len  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.SUB   = 1'b0;
        bus.A     = 8'hFF;
        bus.B     = 8'hFF;
        bus1.start = 1'b1;
        bus1.SUB   = 1'b0;
        bus1.A     = 1'b1;
        bus1.B     = 1'b1;

        // Reset held with start asserted.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_busy", 32'(bus.busy), 32'd0);
            check_eq("rst_done", 32'(bus.done), 32'd0);
            check_eq("rst_S", 32'(bus.S), 32'd0);
            check_eq("rst_CO", 32'(bus.CO), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        bus.start  = 1'b0;
        bus1.start = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);

        drive_op(8'h35, 8'h4A, 1'b0);
        wait_done(20);
        @(posedge clk);
        #1;
        drive_op(8'hFF, 8'h01, 1'b0);
        wait_done(20);
        @(negedge clk);
        check_eq("hold_S", 32'(bus.S), 32'h00);
        check_eq("hold_CO", 32'(bus.CO), 32'd1);
        drive_op(8'h10, 8'h20, 1'b1);
        wait_done(20);

        // Back-to-back: new request in the done cycle, plus a stray start mid-run.
        drive_op(8'h05, 8'h03, 1'b1);
        @(negedge clk);
        check_eq("b2b_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.A     = 8'hAA;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(20);

        for (int i = 0; i < 6; i++) begin
            drive_op(W'($urandom), W'($urandom), 1'($urandom));
            wait_done(20);
        end

        // Abort during the fourth RUN cycle.
        @(posedge clk);
        #1;
        drive_op(8'hC3, 8'h5A, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_S", 32'(bus.S), 32'd0);
        check_eq("abort_CO", 32'(bus.CO), 32'd0);
        repeat (12) @(negedge clk);
        drive_op(8'h01, 8'h01, 1'b0);
        wait_done(20);

        // Minimum width: one RUN cycle then DONE.
        @(posedge clk);
        #1;
        bus1.A     = 1'b1;
        bus1.B     = 1'b1;
        bus1.SUB   = 1'b0;
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        @(negedge clk);
        check_eq("w1_busy", 32'(bus1.busy), 32'd1);
        check_eq("w1_early_done", 32'(bus1.done), 32'd0);
        @(negedge clk);
        check_eq("w1_done", 32'(bus1.done), 32'd1);
        check_eq("w1_S", 32'(bus1.S), 32'd0);
        check_eq("w1_CO", 32'(bus1.CO), 32'd1);
        check_eq("w1_busy_off", 32'(bus1.busy), 32'd0);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
